// File: rtl/batcharger_adc_sched.sv
// batcharger_adc_sched
// Shares one 8-bit ADC between the battery voltage (V), current (I) and
// temperature (T) channels. The enabled channels are converted in round-robin
// order. Each result is held in its own register, and vtok reports that every
// enabled channel holds a fresh, fault-free result.
//
// Ports:
//   clk                    scheduler clock
//   rst                    asynchronous reset, active-high
//   en                     block enable; low -> IDLE, results invalidated, fault cleared
//   vmonen/imonen/tmonen   per-channel conversion requests
//   adc_sel                ADC input mux (00=V, 01=I, 10=T)
//   adc_start              one-cycle conversion start pulse
//   adc_done, adc_data     conversion-complete strobe and result
//   vbat/ibat/tbat         last result of each channel
//   vtok                   all enabled channels valid and no fault
//   adc_err                sticky conversion-timeout fault
module batcharger_adc_sched #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vmonen,
  input  logic       imonen,
  input  logic       tmonen,
  output logic [1:0] adc_sel,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] vbat,
  output logic [7:0] ibat,
  output logic [7:0] tbat,
  output logic       vtok,
  output logic       adc_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_START  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  localparam logic [1:0] CH_V = 2'd0;
  localparam logic [1:0] CH_I = 2'd1;
  localparam logic [1:0] CH_T = 2'd2;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [1:0]       rr;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       valid;

  logic [2:0] monen;
  logic [1:0] rr_p1;
  logic [1:0] rr_p2;
  logic [1:0] pick;
  logic [2:0] done_mask;

  assign monen = {tmonen, imonen, vmonen};

  // Channel that follows c in the V -> I -> T -> V ring.
  function automatic logic [1:0] next_ch(input logic [1:0] c);
    next_ch = (c == CH_T) ? CH_V : c + 2'd1;
  endfunction

  // First requested channel at or after the round-robin pointer.
  assign rr_p1 = next_ch(rr);
  assign rr_p2 = next_ch(rr_p1);

  always_comb begin
    pick = rr_p2;
    if (monen[rr])
      pick = rr;
    else if (monen[rr_p1])
      pick = rr_p1;
  end

  // Valid bit set by a completing conversion of the selected channel.
  assign done_mask = 3'b001 << adc_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr        <= CH_V;
      cnt       <= '0;
      adc_sel   <= CH_V;
      adc_start <= 1'b0;
      vbat      <= 8'h00;
      ibat      <= 8'h00;
      tbat      <= 8'h00;
      valid     <= 3'b000;
      adc_err   <= 1'b0;
    end else if (!en) begin
      // Abandon any conversion in flight; data registers keep their values.
      state     <= ST_IDLE;
      adc_start <= 1'b0;
      valid     <= 3'b000;
      adc_err   <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      // A channel that is no longer requested loses its valid bit every cycle.
      valid     <= valid & monen;

      case (state)
        ST_IDLE: begin
          if (|monen) begin
            adc_sel <= pick;
            cnt     <= '0;
            state   <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            adc_start <= 1'b1;
            state     <= ST_START;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_START: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          // A done arriving on the timeout cycle takes priority over the fault.
          if (adc_done) begin
            case (adc_sel)
              CH_V:    vbat <= adc_data;
              CH_I:    ibat <= adc_data;
              CH_T:    tbat <= adc_data;
              default: ;
            endcase
            // Data still lands for a channel dropped mid-conversion, but its
            // valid bit is masked off.
            valid <= (valid | done_mask) & monen;
            rr    <= next_ch(adc_sel);
            state <= ST_IDLE;
          end else if (cnt == TIMEOUT_LAST) begin
            adc_err <= 1'b1;
            valid   <= 3'b000;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign vtok = en & ~adc_err & (|monen)
              & (~vmonen | valid[0])
              & (~imonen | valid[1])
              & (~tmonen | valid[2]);

endmodule
